// File: rtl/pu_pkg.sv
// rtl/pu_pkg.sv - shared loader state type, window sizes and round base addresses
// Contents:
//   pu_state_t  : loader FSM states IDLE, LOAD, FIRE, WAIT
//   WEIGHT_SIZE : words loaded in round 0 (full window)
//   COL_SIZE    : words loaded in every later round (one new column)
//   BASE_ROUND0 : first register-file address written in round 0
//   BASE_ROUNDN : first register-file address written in rounds > 0
package pu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIRE = 2'd2,
    WAIT = 2'd3
  } pu_state_t;

  localparam int WEIGHT_SIZE = 25;
  localparam int COL_SIZE    = 5;
  localparam int BASE_ROUND0 = 0;
  localparam int BASE_ROUNDN = 20;

endpackage

// File: rtl/pair_packer.sv
// rtl/pair_packer.sv - packs accepted pixel words into paired register-file writes
// Ports:
//   clk, nrst            : clock, asynchronous active-low reset
//   flush                : drop any held word and suppress the next write
//   beat                 : a word is accepted this cycle
//   beat_data/beat_addr  : accepted word and its destination address
//   beat_last            : accepted word is the final word of the round
//   wr_ctrl_g            : one-cycle register-file write strobe
//   adrs_in1/adrs_in2    : write addresses (equal for a lone final word)
//   new1/new2            : write data (equal for a lone final word)
module pair_packer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDRESS_NUM = 5
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   flush,
  input  logic                   beat,
  input  logic [DATA_WIDTH-1:0]  beat_data,
  input  logic [ADDRESS_NUM-1:0] beat_addr,
  input  logic                   beat_last,
  output logic                   wr_ctrl_g,
  output logic [ADDRESS_NUM-1:0] adrs_in1,
  output logic [ADDRESS_NUM-1:0] adrs_in2,
  output logic [DATA_WIDTH-1:0]  new1,
  output logic [DATA_WIDTH-1:0]  new2
);

  logic                   held_valid;
  logic [DATA_WIDTH-1:0]  held_data;
  logic [ADDRESS_NUM-1:0] held_addr;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      held_valid <= 1'b0;
      held_data  <= '0;
      held_addr  <= '0;
      wr_ctrl_g  <= 1'b0;
      adrs_in1   <= '0;
      adrs_in2   <= '0;
      new1       <= '0;
      new2       <= '0;
    end else if (flush) begin
      held_valid <= 1'b0;
      wr_ctrl_g  <= 1'b0;
    end else begin
      wr_ctrl_g <= 1'b0;
      if (beat) begin
        if (held_valid) begin
          // Odd word closes the pair started by the held even word.
          wr_ctrl_g  <= 1'b1;
          adrs_in1   <= held_addr;
          adrs_in2   <= beat_addr;
          new1       <= held_data;
          new2       <= beat_data;
          held_valid <= 1'b0;
        end else if (beat_last) begin
          // Final even word has no partner: write it to both ports.
          wr_ctrl_g <= 1'b1;
          adrs_in1  <= beat_addr;
          adrs_in2  <= beat_addr;
          new1      <= beat_data;
          new2      <= beat_data;
        end else begin
          held_valid <= 1'b1;
          held_data  <= beat_data;
          held_addr  <= beat_addr;
        end
      end
    end
  end

endmodule

// File: rtl/pu_loader.sv
// rtl/pu_loader.sv - streams pixel windows into the PU register file, round by round
// Optional feature macro: PU_LOADER_STALL_CNT_EN (adds stall_cnt output)
// Ports:
//   clk, nrst          : clock, asynchronous active-low reset
//   go                 : frame start pulse (IDLE only)
//   num_rounds         : index of the last round of the frame
//   clr                : synchronous abort back to IDLE
//   s_valid/s_data     : pixel stream in; s_ready accepts words in LOAD
//   pu_done            : PU finished the current window (WAIT only)
//   wr_ctrl_g, adrs_in1/2, new1/2 : register-file write port
//   start              : one-cycle PU window start
//   round              : current round; busy : not IDLE; frame_done : end-of-frame pulse
//   stall_cnt          : LOAD cycles starved by the stream (macro only)
module pu_loader
  import pu_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int WEIGHT_SIZE = pu_pkg::WEIGHT_SIZE,
  parameter int ADDRESS_NUM = 5,
  parameter int COL_SIZE    = pu_pkg::COL_SIZE
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   go,
  input  logic [5:0]             num_rounds,
  input  logic                   clr,
  input  logic                   s_valid,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic                   s_ready,
  input  logic                   pu_done,
  output logic                   wr_ctrl_g,
  output logic [ADDRESS_NUM-1:0] adrs_in1,
  output logic [ADDRESS_NUM-1:0] adrs_in2,
  output logic [DATA_WIDTH-1:0]  new1,
  output logic [DATA_WIDTH-1:0]  new2,
  output logic                   start,
  output logic [5:0]             round,
  output logic                   busy,
  output logic                   frame_done
`ifdef PU_LOADER_STALL_CNT_EN
  ,output logic [15:0]           stall_cnt
`endif
);

  localparam int CNT_W = $clog2(WEIGHT_SIZE + 1);

  pu_state_t              state, state_nx;
  logic [CNT_W-1:0]       word_cnt;
  logic [CNT_W-1:0]       word_total;
  logic [ADDRESS_NUM-1:0] base_addr;
  logic [ADDRESS_NUM-1:0] word_addr;
  logic [5:0]             last_round;
  logic                   all_loaded;
  logic                   beat;
  logic                   beat_last;

  // Round 0 fills the whole window; later rounds only refresh the last column.
  assign word_total = (round == 6'd0) ? CNT_W'(WEIGHT_SIZE) : CNT_W'(COL_SIZE);
  assign base_addr  = (round == 6'd0) ? ADDRESS_NUM'(BASE_ROUND0) : ADDRESS_NUM'(BASE_ROUNDN);
  assign word_addr  = base_addr + ADDRESS_NUM'(word_cnt);
  assign all_loaded = (word_cnt == word_total);
  assign beat_last  = (word_cnt == word_total - CNT_W'(1));

  // s_ready drops once every word of the round is in, so the final write
  // can drain while the FSM waits in LOAD for one more cycle.
  assign s_ready = (state == LOAD) && !all_loaded;
  assign beat    = s_valid && s_ready && !clr;
  assign start   = (state == FIRE);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (go) state_nx = LOAD;
      LOAD: if (all_loaded) state_nx = FIRE;
      FIRE: state_nx = WAIT;
      WAIT: if (pu_done) state_nx = (round == last_round) ? IDLE : LOAD;
      default: state_nx = IDLE;
    endcase
    if (clr) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      round      <= '0;
      word_cnt   <= '0;
      last_round <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= 1'b0;
      if (clr) begin
        round    <= '0;
        word_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (go) begin
            last_round <= num_rounds;
            word_cnt   <= '0;
          end
          LOAD: if (beat) word_cnt <= word_cnt + CNT_W'(1);
          WAIT: if (pu_done) begin
            word_cnt <= '0;
            if (round == last_round) begin
              round      <= '0;
              frame_done <= 1'b1;
            end else begin
              round <= round + 6'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PU_LOADER_STALL_CNT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_cnt <= '0;
    end else if (clr || (state == IDLE && go)) begin
      stall_cnt <= '0;
    end else if (s_ready && !s_valid && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  pair_packer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDRESS_NUM (ADDRESS_NUM)
  ) u_pair_packer (
    .clk       (clk),
    .nrst      (nrst),
    .flush     (clr),
    .beat      (beat),
    .beat_data (s_data),
    .beat_addr (word_addr),
    .beat_last (beat_last),
    .wr_ctrl_g (wr_ctrl_g),
    .adrs_in1  (adrs_in1),
    .adrs_in2  (adrs_in2),
    .new1      (new1),
    .new2      (new2)
  );

endmodule
